ctrl_decode_stage: RTL and testbench

Registered, parametrised instruction-decode stage that turns `{opcode, func}` into datapath control signals. It sits between fetch and execute in the windowed-register CPU. Unlike the single-cycle decoder it replaces, it adds:
- valid/ready handshakes on both sides, so back-pressure stalls are safe;
- a memory-wait state machine;
- a configurable post-jump squash window;
- an illegal-opcode flag.

---
 rtl/ctrl_pkg.sv | 29 ++
 rtl/ctrl_decode_comb.sv | 46 ++++
 rtl/ctrl_decode_stage.sv | 93 +++++++++
 tb/tb_ctrl_decode_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, ALU constants, FSM states and control bundle for the decode stage
package ctrl_pkg;
  localparam logic [3:0] OP_LOAD   = 4'b0000;
  localparam logic [3:0] OP_STORE  = 4'b0001;
  localparam logic [3:0] OP_JUMP   = 4'b0010;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_RTYPE  = 4'b1000;
  localparam logic [3:0] OP_IMM0   = 4'b1100;
  localparam logic [3:0] OP_IMM1   = 4'b1101;
  localparam logic [3:0] OP_IMM2   = 4'b1110;
  localparam logic [3:0] OP_IMM3   = 4'b1111;
  localparam logic [6:0] ALU_BRANCH = 7'b1000111;
  localparam logic [6:0] ALU_IMM_BASE = 7'b0000010;
  typedef enum logic [1:0] {IDLE, MEM_WAIT, FLUSH} ctrl_state_t;
  typedef struct packed {
    logic set_window;
    logic jump;
    logic mem_write;
    logic mem_read;
    logic immd_sel;
    logic mem_or_alu;
    logic to_write;
    logic illegal;
    logic mem_req;
  } ctrl_bundle_t;
  function automatic logic [6:0] imm_alu(input logic [1:0] sel);
    return ALU_IMM_BASE << sel;
  endfunction
endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: combinational {opcode, func} to control bundle lookup
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int FUNC_W = 8,
  parameter int ALU_W  = 7
) (
  input  logic [OP_W-1:0]   opcode,
  input  logic [FUNC_W-1:0] func,
  output ctrl_bundle_t      bundle,
  output logic [ALU_W-1:0]  alu_op
);
  // any nonzero bit above the 4 decoded bits makes the opcode illegal
  always_comb begin
    bundle = '0;
    alu_op = '0;
    if (|(opcode >> 4)) bundle.illegal = 1'b1;
    else
      case (opcode[3:0])
        OP_LOAD: begin
          bundle.mem_read = 1'b1;
          bundle.to_write = 1'b1;
          bundle.mem_or_alu = 1'b1;
          bundle.mem_req = 1'b1;
        end
        OP_STORE: begin
          bundle.mem_write = 1'b1;
          bundle.mem_req = 1'b1;
        end
        OP_JUMP: bundle.jump = 1'b1;
        OP_BRANCH: alu_op = ALU_W'(ALU_BRANCH);
        OP_RTYPE: begin
          alu_op = func[ALU_W-1:0];
          bundle.set_window = func[FUNC_W-1];
          bundle.to_write = func[FUNC_W-1 -: 2] == 2'b00;
        end
        OP_IMM0, OP_IMM1, OP_IMM2, OP_IMM3: begin
          bundle.immd_sel = 1'b1;
          bundle.to_write = 1'b1;
          alu_op = ALU_W'(imm_alu(opcode[1:0]));
        end
        default: bundle.illegal = 1'b1;
      endcase
  end
endmodule

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered decode stage with handshakes, memory wait and post-jump squash
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int OP_W         = 4,
  parameter int FUNC_W       = 8,
  parameter int ALU_W        = 7,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [FUNC_W-1:0] func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              setWindow,
  output logic              jump,
  output logic              mem_write,
  output logic              mem_read,
  output logic              immdSel,
  output logic              memOrALU,
  output logic              toWrite,
  output logic              illegal,
  output logic [ALU_W-1:0]  ALUop,
  output logic              mem_req,
  input  logic              mem_done
);
  ctrl_state_t state, state_n;
  ctrl_bundle_t dec, bq;
  logic [ALU_W-1:0] dec_alu, alu_q;
  logic [2:0] flush_cnt;
  logic valid_q, done_seen, accept, retire, v;
  ctrl_decode_comb #(.OP_W(OP_W), .FUNC_W(FUNC_W), .ALU_W(ALU_W)) u_dec (
    .opcode(opcode),
    .func(func),
    .bundle(dec),
    .alu_op(dec_alu)
  );
  // handshakes and next state; a latched mem_done counts as done for retirement
  always_comb begin
    in_ready = !rst && (state == IDLE ? (!valid_q || out_ready) : state == FLUSH);
    accept = in_valid && in_ready;
    retire = state == MEM_WAIT && (mem_done || done_seen) && out_ready;
    state_n = state;
    case (state)
      IDLE: state_n = !accept ? IDLE : dec.mem_req ? MEM_WAIT : (dec.jump && FLUSH_CYCLES > 0) ? FLUSH : IDLE;
      MEM_WAIT: state_n = retire ? IDLE : MEM_WAIT;
      FLUSH: state_n = (accept && flush_cnt == 3'd1) ? IDLE : FLUSH;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // output register, squash counter and latched mem_done
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      bq <= '0;
      alu_q <= '0;
      flush_cnt <= 3'd0;
      done_seen <= 1'b0;
    end else begin
      if (state == IDLE && accept) begin
        valid_q <= 1'b1;
        bq <= dec;
        alu_q <= dec_alu;
      end else if (state == MEM_WAIT ? retire : out_ready) valid_q <= 1'b0;
      if (state == IDLE && accept && dec.jump) flush_cnt <= 3'(FLUSH_CYCLES);
      else if (state == FLUSH && accept) flush_cnt <= flush_cnt - 3'd1;
      done_seen <= state == MEM_WAIT && !retire && (done_seen || mem_done);
    end
  end
  // outputs read as zero whenever no bundle is shown or reset is held
  always_comb begin
    v = valid_q && !rst;
    out_valid = v;
    setWindow = v && bq.set_window;
    jump = v && bq.jump;
    mem_write = v && bq.mem_write;
    mem_read = v && bq.mem_read;
    immdSel = v && bq.immd_sel;
    memOrALU = v && bq.mem_or_alu;
    toWrite = v && bq.to_write;
    illegal = v && bq.illegal;
    mem_req = v && bq.mem_req;
    ALUop = v ? alu_q : '0;
  end
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: table vectors, directed corner sequences and randomized scoreboard run
module tb_ctrl_decode_stage;
  localparam int FC = 2;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, mem_done = 0;
  logic [3:0] opcode = 0;
  logic [7:0] func = 0;
  logic in_ready, out_valid, setWindow, jump, mem_write, mem_read, immdSel, memOrALU, toWrite, illegal, mem_req;
  logic [6:0] ALUop;
  logic [15:0] obs;
  int n_vec = 0, n_err = 0;

  ctrl_decode_stage #(.OP_W(4), .FUNC_W(8), .ALU_W(7), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .func(func),
    .out_valid(out_valid), .out_ready(out_ready), .setWindow(setWindow), .jump(jump),
    .mem_write(mem_write), .mem_read(mem_read), .immdSel(immdSel), .memOrALU(memOrALU),
    .toWrite(toWrite), .illegal(illegal), .ALUop(ALUop), .mem_req(mem_req), .mem_done(mem_done)
  );

  always #5 clk = ~clk;
  assign obs = {ALUop, setWindow, jump, mem_write, mem_read, immdSel, memOrALU, toWrite, illegal, mem_req};

  typedef struct {
    logic [3:0] op;
    logic [7:0] fn;
    logic [6:0] alu;
    logic [8:0] bits;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [3:0] op, input logic [7:0] fn, input logic ordy, input logic md);
    in_valid = iv;
    opcode = op;
    func = fn;
    out_ready = ordy;
    mem_done = md;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model(input logic [3:0] op, input logic [7:0] fn);
    if (op == 4'd0) return {7'd0, 9'b000101101};
    if (op == 4'd1) return {7'd0, 9'b001000001};
    if (op == 4'd2) return {7'd0, 9'b010000000};
    if (op == 4'd4) return {7'h47, 9'b0};
    if (op == 4'd8) return {fn[6:0], fn[7], 5'b0, fn[7:6] == 2'b00, 2'b0};
    if (op >= 4'd12) return {7'(1 << (op - 4'd11)), 9'b000010100};
    return {7'd0, 9'b000000010};
  endfunction

  vec_t tbl[12];
  logic [15:0] q[$];
  int squash;
  bit done_flag, ov_e, mem_shown, ir_e, acc, ret, iv, ordy, md;
  logic [3:0] op;
  logic [7:0] fn;

  initial begin
    tbl[0]  = '{4'hC, 8'h00, 7'h02, 9'b000010100};
    tbl[1]  = '{4'hD, 8'hFF, 7'h04, 9'b000010100};
    tbl[2]  = '{4'hE, 8'h5A, 7'h08, 9'b000010100};
    tbl[3]  = '{4'hF, 8'h00, 7'h10, 9'b000010100};
    tbl[4]  = '{4'h8, 8'h85, 7'h05, 9'b100000000};
    tbl[5]  = '{4'h8, 8'h03, 7'h03, 9'b000000100};
    tbl[6]  = '{4'h8, 8'h4C, 7'h4C, 9'b000000000};
    tbl[7]  = '{4'h4, 8'hA5, 7'h47, 9'b000000000};
    tbl[8]  = '{4'h3, 8'h00, 7'h00, 9'b000000010};
    tbl[9]  = '{4'h5, 8'h11, 7'h00, 9'b000000010};
    tbl[10] = '{4'h9, 8'h85, 7'h00, 9'b000000010};
    tbl[11] = '{4'hB, 8'h00, 7'h00, 9'b000000010};

    rst = 1;
    for (int i = 0; i < 2; i++) begin
      step(1, 4'hC, 8'h00, 1, 0);
      chk("reset_out", 32'({out_valid, obs}), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
    end
    rst = 0;
    step(0, 4'h0, 8'h00, 1, 0);
    chk("post_reset_idle", 32'({out_valid, obs}), 32'd0);

    for (int i = 0; i < 12; i++) begin
      step(1, tbl[i].op, tbl[i].fn, 1, 0);
      chk("table", 32'({out_valid, obs}), 32'({1'b1, tbl[i].alu, tbl[i].bits}));
    end
    step(0, 4'h0, 8'h00, 1, 0);
    chk("table_drain", 32'(out_valid), 32'd0);

    step(1, 4'h0, 8'h00, 1, 0);
    chk("load_accept", 32'({out_valid, obs}), 32'({1'b1, 7'd0, 9'b000101101}));
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; opcode = 4'hC; out_ready = 1; mem_done = 0;
      #1;
      chk("load_wait_in_ready", 32'(in_ready), 32'd0);
      step(1, 4'hC, 8'h00, 1, 0);
      chk("load_wait_hold", 32'({out_valid, mem_req, mem_read}), 32'b111);
    end
    step(0, 4'h0, 8'h00, 0, 1);
    chk("load_done_no_ready", 32'({out_valid, mem_req, in_ready}), 32'b110);
    step(0, 4'h0, 8'h00, 1, 0);
    chk("load_retire", 32'({out_valid, mem_req}), 32'd0);

    step(1, 4'h1, 8'h00, 1, 0);
    chk("store_accept", 32'({out_valid, obs}), 32'({1'b1, 7'd0, 9'b001000001}));
    step(0, 4'h0, 8'h00, 1, 1);
    chk("store_one_cycle", 32'({out_valid, mem_req}), 32'd0);

    step(1, 4'h2, 8'h00, 1, 0);
    chk("jump_emit", 32'({out_valid, obs}), 32'({1'b1, 7'd0, 9'b010000000}));
    step(0, 4'h0, 8'h00, 1, 0);
    chk("jump_gap", 32'(out_valid), 32'd0);
    step(1, 4'hC, 8'h00, 1, 0);
    chk("squash_1", 32'(out_valid), 32'd0);
    step(1, 4'hD, 8'h00, 1, 0);
    chk("squash_2", 32'(out_valid), 32'd0);
    step(1, 4'hE, 8'h00, 1, 0);
    chk("after_squash", 32'({out_valid, obs}), 32'({1'b1, 7'h08, 9'b000010100}));
    step(0, 4'h0, 8'h00, 1, 0);

    step(1, 4'h0, 8'h00, 1, 0);
    step(0, 4'h0, 8'h00, 0, 1);
    chk("rst_wait_pre", 32'({out_valid, mem_req}), 32'b11);
    rst = 1;
    step(0, 4'h0, 8'h00, 0, 0);
    chk("rst_wait_clear", 32'({out_valid, obs}), 32'd0);
    rst = 0;
    step(0, 4'h0, 8'h00, 0, 1);
    chk("late_done", 32'({out_valid, mem_req, in_ready}), 32'b001);
    step(1, 4'h0, 8'h00, 1, 0);
    step(0, 4'h0, 8'h00, 1, 0);
    chk("latched_done_dropped", 32'({out_valid, mem_req}), 32'b11);
    step(0, 4'h0, 8'h00, 1, 1);
    chk("relaunch_retire", 32'(out_valid), 32'd0);

    squash = 0;
    done_flag = 0;
    for (int c = 0; c < 3000; c++) begin
      iv = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 9))
        0: op = 4'h0;
        1: op = 4'h1;
        2: op = 4'h2;
        default: op = 4'($urandom_range(0, 15));
      endcase
      fn = 8'($urandom);
      ordy = $urandom_range(0, 3) != 0;
      md = $urandom_range(0, 2) == 0;
      in_valid = iv; opcode = op; func = fn; out_ready = ordy; mem_done = md;
      #1;
      ov_e = q.size() > 0;
      mem_shown = ov_e && q[0][0];
      ir_e = squash > 0 ? 1'b1 : mem_shown ? 1'b0 : (!ov_e || ordy);
      chk("rand_valid", 32'(out_valid), 32'(ov_e));
      chk("rand_ready", 32'(in_ready), 32'(ir_e));
      if (ov_e) chk("rand_bundle", 32'(obs), 32'(q[0]));
      acc = iv && ir_e;
      ret = ov_e && ordy && (!mem_shown || md || done_flag);
      if (ret) begin
        void'(q.pop_front());
        done_flag = 0;
      end else if (mem_shown && md) done_flag = 1;
      if (acc) begin
        if (squash > 0) squash--;
        else begin
          q.push_back(model(op, fn));
          if (op == 4'h2) squash = FC;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
